// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the PC, issues sequential requests to a 1-cycle imem and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO toward decode; redirects flush everything.
module fetch_queue_stage #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic [31:0]                imem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic             inflight_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   credit_used;
  logic             redirect_unused;

  // The low address bits of a redirect target are architecturally zero.
  assign redirect_unused = ^redirect_pc[1:0];

  // An outstanding request already owns a slot; a pop this cycle frees nothing until next cycle.
  assign credit_used    = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue          = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
  assign push           = !rst && !redirect_valid && inflight_q;
  assign out_valid      = !rst && !redirect_valid && (count_q != '0);
  assign pop            = out_valid && out_ready;

  assign imem_req_valid = issue;
  assign imem_req_addr  = pc_q;
  assign out_pc         = pc_mem[rd_ptr_q];
  assign out_instr      = instr_mem[rd_ptr_q];
  assign occupancy      = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + XLEN'(4);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: queue storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
      instr_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // The credit rule must make a push into a full queue unreachable.
  overflow_never: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule
